word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_pkg.sv | 6 +
 rtl/word_serializer_mux.sv | 10 +
 rtl/word_serializer.sv | 56 +++++
 tb/tb_word_serializer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared widths and FSM encoding for the word serializer.
package word_serializer_pkg;
    localparam int WORD_W = 32;
    localparam int IDX_W = 5;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/word_serializer_mux.sv
// mux_32to1: selects one bit of a 32-bit word by a 5-bit index.
module mux_32to1
    import word_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [IDX_W-1:0]  switch,
    output logic              out
);
    assign out = in[switch];
endmodule

// File: rtl/word_serializer.sv
// word_serializer: streams a 32-bit word out one bit per accepted beat,
// reloading on the final beat so back-to-back words leave no bubble.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_data,
    output logic              ser_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              busy
);
    localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(WORD_W - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : IDX_W'(WORD_W - 1);

    state_t             state;
    logic [WORD_W-1:0]  word;
    logic [IDX_W-1:0]   idx;
    logic               mux_out;

    mux_32to1 u_mux (
        .in     (word),
        .switch (idx),
        .out    (mux_out)
    );

    assign ser_valid  = state == SHIFT;
    assign busy       = ser_valid;
    assign ser_last   = ser_valid && idx == LAST_IDX;
    assign ser_bit    = ser_valid && mux_out;
    assign load_ready = !ser_valid || (ser_last && ser_ready);

    // A load on the final beat takes priority over returning to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
            idx   <= '0;
        end else if (load_valid && load_ready) begin
            state <= SHIFT;
            word  <= load_data;
            idx   <= FIRST_IDX;
        end else if (ser_valid && ser_ready) begin
            if (ser_last)
                state <= IDLE;
            else
                idx <= MSB_FIRST ? idx - 5'd1 : idx + 5'd1;
        end
    end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench for LSB-first and MSB-first serializers.
module tb_word_serializer;
    typedef struct packed {logic b; logic l;} exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic lv0 = 1'b0, sr0 = 1'b0, lr0, sb0, sv0, sl0, bz0;
    logic lv1 = 1'b0, sr1 = 1'b0, lr1, sb1, sv1, sl1, bz1;
    logic [31:0] ld0 = '0, ld1 = '0;
    exp_t q0[$], q1[$];
    int cmp = 0, bad = 0;
    logic exp_lr;

    always #5 clk = ~clk;

    word_serializer #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
        .ser_bit(sb0), .ser_valid(sv0), .ser_ready(sr0), .ser_last(sl0), .busy(bz0)
    );

    word_serializer #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
        .ser_bit(sb1), .ser_valid(sv1), .ser_ready(sr1), .ser_last(sl1), .busy(bz1)
    );

    task automatic push_word(input logic [31:0] w, input bit sel);
        for (int i = 0; i < 32; i++)
            if (sel) q1.push_back(exp_t'{w[31-i], i == 31});
            else q0.push_back(exp_t'{w[i], i == 31});
    endtask

    task automatic test_reset();
        #2;
        cmp += 2;
        if ({sv0, sb0, sl0, bz0, lr0} !== 5'b00001) begin bad++; $display("FAIL reset dut0 got %b want 00001", {sv0, sb0, sl0, bz0, lr0}); end
        if ({sv1, sb1, sl1, bz1, lr1} !== 5'b00001) begin bad++; $display("FAIL reset dut1 got %b want 00001", {sv1, sb1, sl1, bz1, lr1}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp += 2;
        if ({lr0, sv0} !== 2'b10) begin bad++; $display("FAIL release dut0 ready/valid got %b want 10", {lr0, sv0}); end
        if ({lr1, sv1} !== 2'b10) begin bad++; $display("FAIL release dut1 ready/valid got %b want 10", {lr1, sv1}); end
        @(posedge clk);
    endtask

    task automatic test_lsb_first();
        for (int c = 0; c < 40; c++) begin
            #1;
            lv0 = (c == 0); ld0 = 32'hA5A5_0F0F; sr0 = 1'b1;
            #1;
            exp_lr = q0.size() == 0 || (q0.size() == 1 && sr0);
            cmp += 3;
            if ({sv0, bz0} !== {2{q0.size() != 0}}) begin bad++; $display("FAIL lsb c%0d valid/busy got %b want %b", c, {sv0, bz0}, {2{q0.size() != 0}}); end
            if (lr0 !== exp_lr) begin bad++; $display("FAIL lsb c%0d ready got %b want %b", c, lr0, exp_lr); end
            if ({sb0, sl0} !== (q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00)) begin bad++; $display("FAIL lsb c%0d bit/last got %b want %b", c, {sb0, sl0}, q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00); end
            if (q0.size() != 0 && sr0) void'(q0.pop_front());
            if (lv0 && exp_lr) push_word(ld0, 1'b0);
            @(posedge clk);
        end
    endtask

    task automatic test_msb_first();
        for (int c = 0; c < 40; c++) begin
            #1;
            lv1 = (c == 0); ld1 = 32'h8000_0001; sr1 = 1'b1;
            #1;
            exp_lr = q1.size() == 0 || (q1.size() == 1 && sr1);
            cmp += 3;
            if ({sv1, bz1} !== {2{q1.size() != 0}}) begin bad++; $display("FAIL msb c%0d valid/busy got %b want %b", c, {sv1, bz1}, {2{q1.size() != 0}}); end
            if (lr1 !== exp_lr) begin bad++; $display("FAIL msb c%0d ready got %b want %b", c, lr1, exp_lr); end
            if ({sb1, sl1} !== (q1.size() != 0 ? {q1[0].b, q1[0].l} : 2'b00)) begin bad++; $display("FAIL msb c%0d bit/last got %b want %b", c, {sb1, sl1}, q1.size() != 0 ? {q1[0].b, q1[0].l} : 2'b00); end
            if (q1.size() != 0 && sr1) void'(q1.pop_front());
            if (lv1 && exp_lr) push_word(ld1, 1'b1);
            @(posedge clk);
        end
        lv1 = 1'b0; sr1 = 1'b0;
    endtask

    task automatic test_stall();
        for (int c = 0; c < 68; c++) begin
            #1;
            lv0 = (c == 0); ld0 = 32'hDEAD_BEEF; sr0 = c[0];
            #1;
            exp_lr = q0.size() == 0 || (q0.size() == 1 && sr0);
            cmp += 3;
            if ({sv0, bz0} !== {2{q0.size() != 0}}) begin bad++; $display("FAIL stall c%0d valid/busy got %b want %b", c, {sv0, bz0}, {2{q0.size() != 0}}); end
            if (lr0 !== exp_lr) begin bad++; $display("FAIL stall c%0d ready got %b want %b", c, lr0, exp_lr); end
            if ({sb0, sl0} !== (q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00)) begin bad++; $display("FAIL stall c%0d bit/last got %b want %b", c, {sb0, sl0}, q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00); end
            if (q0.size() != 0 && sr0) void'(q0.pop_front());
            if (lv0 && exp_lr) push_word(ld0, 1'b0);
            @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        for (int c = 0; c < 70; c++) begin
            #1;
            lv0 = k < 2; ld0 = k == 0 ? 32'h0000_FFFF : 32'hFFFF_0000; sr0 = 1'b1;
            #1;
            exp_lr = q0.size() == 0 || (q0.size() == 1 && sr0);
            cmp += 3;
            if ({sv0, bz0} !== {2{q0.size() != 0}}) begin bad++; $display("FAIL b2b c%0d valid/busy got %b want %b", c, {sv0, bz0}, {2{q0.size() != 0}}); end
            if (lr0 !== exp_lr) begin bad++; $display("FAIL b2b c%0d ready got %b want %b", c, lr0, exp_lr); end
            if ({sb0, sl0} !== (q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00)) begin bad++; $display("FAIL b2b c%0d bit/last got %b want %b", c, {sb0, sl0}, q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00); end
            if (q0.size() != 0 && sr0) void'(q0.pop_front());
            if (lv0 && exp_lr) begin push_word(ld0, 1'b0); k++; end
            @(posedge clk);
        end
    endtask

    task automatic test_ignore_load();
        for (int c = 0; c < 40; c++) begin
            #1;
            lv0 = c == 0 || (c >= 5 && c <= 10); ld0 = c == 0 ? 32'h0 : 32'hFFFF_FFFF; sr0 = 1'b1;
            #1;
            exp_lr = q0.size() == 0 || (q0.size() == 1 && sr0);
            cmp += 3;
            if ({sv0, bz0} !== {2{q0.size() != 0}}) begin bad++; $display("FAIL ignore c%0d valid/busy got %b want %b", c, {sv0, bz0}, {2{q0.size() != 0}}); end
            if (lr0 !== exp_lr) begin bad++; $display("FAIL ignore c%0d ready got %b want %b", c, lr0, exp_lr); end
            if ({sb0, sl0} !== (q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00)) begin bad++; $display("FAIL ignore c%0d bit/last got %b want %b", c, {sb0, sl0}, q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00); end
            if (q0.size() != 0 && sr0) void'(q0.pop_front());
            if (lv0 && exp_lr) push_word(ld0, 1'b0);
            @(posedge clk);
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 11; c++) begin
            #1;
            lv0 = (c == 0); ld0 = 32'h1234_5678; sr0 = 1'b1;
            #1;
            exp_lr = q0.size() == 0 || (q0.size() == 1 && sr0);
            cmp += 2;
            if ({sv0, bz0} !== {2{q0.size() != 0}}) begin bad++; $display("FAIL midrst c%0d valid/busy got %b want %b", c, {sv0, bz0}, {2{q0.size() != 0}}); end
            if ({sb0, sl0} !== (q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00)) begin bad++; $display("FAIL midrst c%0d bit/last got %b want %b", c, {sb0, sl0}, q0.size() != 0 ? {q0[0].b, q0[0].l} : 2'b00); end
            if (q0.size() != 0 && sr0) void'(q0.pop_front());
            if (lv0 && exp_lr) push_word(ld0, 1'b0);
            @(posedge clk);
        end
        // Bit 10 is now on the wire; assert reset between edges.
        #3;
        lv0 = 1'b0;
        rst_n = 1'b0;
        #1;
        cmp++;
        if ({sv0, sb0, sl0, bz0} !== 4'b0000) begin bad++; $display("FAIL midrst async outputs got %b want 0000", {sv0, sb0, sl0, bz0}); end
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            #2;
            cmp += 2;
            if (lr0 !== 1'b1) begin bad++; $display("FAIL midrst post c%0d ready got %b want 1", c, lr0); end
            if ({sv0, sb0, sl0, bz0} !== 4'b0000) begin bad++; $display("FAIL midrst post c%0d stale got %b want 0000", c, {sv0, sb0, sl0, bz0}); end
            @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_stall();
        test_back_to_back();
        test_ignore_load();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
